// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: pops PS/2 set-2 scan bytes from a receive FIFO and tracks the held key
module ps2_scan_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [7:0]       data,
    input  logic             ready,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_valid,
    output logic [7:0]       key_ascii,
    output logic [CNT_W-1:0] press_cnt,
    output logic             make_evt,
    output logic             break_evt,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;
    state_t state, state_nx;
    logic [7:0] byte_q;
    logic [7:0] asc;
    logic ext_pend, brk_pend;
    logic is_ext, is_brk, is_junk, same_key;
    assign is_ext   = byte_q == 8'hE0;
    assign is_brk   = byte_q == 8'hF0;
    assign is_junk  = byte_q inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    assign same_key = key_valid && byte_q == key_code && ext_pend == key_ext;
    // state register; clr drops any in-flight pop
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nx;
    end
    // next state and pop strobe; ready only matters in IDLE
    always_comb begin
        state_nx   = IDLE;
        nextdata_n = 1'b1;
        if (state == IDLE && ready) state_nx = POP;
        if (state == POP) begin
            state_nx   = SETTLE;
            nextdata_n = 1'b0;
        end
    end
    // byte latch and decode of the latched byte at the end of POP
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            byte_q    <= 8'h00;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            key_code  <= 8'h00;
            key_ext   <= 1'b0;
            key_valid <= 1'b0;
            press_cnt <= '0;
            make_evt  <= 1'b0;
            break_evt <= 1'b0;
        end else begin
            make_evt  <= 1'b0;
            break_evt <= 1'b0;
            if (state == IDLE && ready) byte_q <= data;
            if (state == POP) begin
                if (is_ext) ext_pend <= 1'b1;
                else if (is_brk) brk_pend <= 1'b1;
                else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                    if (!is_junk && brk_pend && same_key) begin
                        key_valid <= 1'b0;
                        break_evt <= 1'b1;
                    end
                    if (!is_junk && !brk_pend && !same_key) begin
                        key_code  <= byte_q;
                        key_ext   <= ext_pend;
                        key_valid <= 1'b1;
                        press_cnt <= press_cnt + CNT_W'(1);
                        make_evt  <= 1'b1;
                    end
                end
            end
        end
    end
    // sticky overflow flag
    always_ff @(posedge clk or posedge clr) begin
        if (clr)           err <= 1'b0;
        else if (overflow) err <= 1'b1;
    end
    // set-2 to ASCII lookup for letters, digits, space and enter
    always_comb begin
        asc = 8'h00;
        case (key_code)
            8'h1C: asc = 8'h61;
            8'h32: asc = 8'h62;
            8'h21: asc = 8'h63;
            8'h23: asc = 8'h64;
            8'h24: asc = 8'h65;
            8'h2B: asc = 8'h66;
            8'h34: asc = 8'h67;
            8'h33: asc = 8'h68;
            8'h43: asc = 8'h69;
            8'h3B: asc = 8'h6A;
            8'h42: asc = 8'h6B;
            8'h4B: asc = 8'h6C;
            8'h3A: asc = 8'h6D;
            8'h31: asc = 8'h6E;
            8'h44: asc = 8'h6F;
            8'h4D: asc = 8'h70;
            8'h15: asc = 8'h71;
            8'h2D: asc = 8'h72;
            8'h1B: asc = 8'h73;
            8'h2C: asc = 8'h74;
            8'h3C: asc = 8'h75;
            8'h2A: asc = 8'h76;
            8'h1D: asc = 8'h77;
            8'h22: asc = 8'h78;
            8'h35: asc = 8'h79;
            8'h1A: asc = 8'h7A;
            8'h45: asc = 8'h30;
            8'h16: asc = 8'h31;
            8'h1E: asc = 8'h32;
            8'h26: asc = 8'h33;
            8'h25: asc = 8'h34;
            8'h2E: asc = 8'h35;
            8'h36: asc = 8'h36;
            8'h3D: asc = 8'h37;
            8'h3E: asc = 8'h38;
            8'h46: asc = 8'h39;
            8'h29: asc = 8'h20;
            8'h5A: asc = 8'h0D;
            default: asc = 8'h00;
        endcase
    end
    assign key_ascii = (key_valid && !key_ext) ? asc : 8'h00;
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder: FIFO model plus scoreboard of expected make/break events
module tb_ps2_scan_decoder;
    logic clk = 0, clr = 0, ready = 0, overflow = 0;
    logic [7:0] data = 8'h00;
    logic nextdata_n, key_ext, key_valid, make_evt, break_evt, err;
    logic [7:0] key_code, key_ascii, press_cnt;
    int checks = 0, failures = 0, cyc = 0, make_seen = 0;
    typedef struct {
        bit mk;
        logic [7:0] code;
        logic ext;
        logic valid;
        logic [7:0] cnt;
        logic [7:0] asc;
    } ev_t;
    ev_t exp_q[$];
    logic [7:0] fifo[$];
    int pops[$];
    logic [7:0] m_code, m_cnt;
    logic m_ext, m_valid, m_ep, m_bp;
    localparam logic [7:0] LET [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A,
        8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIG [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    ps2_scan_decoder #(.CNT_W(8)) dut (
        .clk(clk), .clr(clr), .data(data), .ready(ready), .overflow(overflow),
        .nextdata_n(nextdata_n), .key_code(key_code), .key_ext(key_ext), .key_valid(key_valid),
        .key_ascii(key_ascii), .press_cnt(press_cnt), .make_evt(make_evt), .break_evt(break_evt),
        .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] ascii_of(logic [7:0] c, logic e, logic v);
        if (!v || e) return 8'h00;
        for (int i = 0; i < 26; i++) if (c == LET[i]) return 8'(8'h61 + i);
        for (int i = 0; i < 10; i++) if (c == DIG[i]) return 8'(8'h30 + i);
        if (c == 8'h29) return 8'h20;
        if (c == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_code = 0; m_cnt = 0; m_ext = 0; m_valid = 0; m_ep = 0; m_bp = 0;
        exp_q.delete();
        fifo.delete();
    endtask

    task automatic feed(input logic [7:0] b);
        ev_t e;
        bit same;
        fifo.push_back(b);
        if (b == 8'hE0) m_ep = 1;
        else if (b == 8'hF0) m_bp = 1;
        else begin
            if (!(b inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
                same = m_valid && b == m_code && m_ep == m_ext;
                if (m_bp && same) begin
                    m_valid = 0;
                    e = '{0, m_code, m_ext, 1'b0, m_cnt, 8'h00};
                    exp_q.push_back(e);
                end else if (!m_bp && !same) begin
                    m_code = b; m_ext = m_ep; m_valid = 1; m_cnt = m_cnt + 8'd1;
                    e = '{1, m_code, m_ext, 1'b1, m_cnt, ascii_of(m_code, m_ext, 1'b1)};
                    exp_q.push_back(e);
                end
            end
            m_ep = 0; m_bp = 0;
        end
    endtask

    // FIFO model: pop the head whenever the strobe is seen low
    initial forever begin
        @(negedge clk);
        if (!clr && nextdata_n === 1'b0) begin
            pops.push_back(cyc);
            if (fifo.size() != 0) void'(fifo.pop_front());
        end
        ready = fifo.size() != 0;
        data = ready ? fifo[0] : 8'h00;
    end

    // event monitor: every pulse must match the head of the scoreboard
    initial begin
        bit prev = 0;
        ev_t e;
        forever begin
            @(negedge clk);
            if (make_evt || break_evt) begin
                checks++;
                if (make_evt && break_evt) begin failures++; $display("FAIL evt_both make=%b break=%b required only one", make_evt, break_evt); end
                checks++;
                if (prev) begin failures++; $display("FAIL evt_width pulse lasted more than one cycle, required one"); end
                if (make_evt) make_seen++;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL evt_unexpected make=%b break=%b code=%h required no event", make_evt, break_evt, key_code);
                end else begin
                    e = exp_q.pop_front();
                    checks += 6;
                    if (make_evt !== e.mk) begin failures++; $display("FAIL evt_type make=%b required %b", make_evt, e.mk); end
                    if (key_code !== e.code) begin failures++; $display("FAIL evt_code got %h required %h", key_code, e.code); end
                    if (key_ext !== e.ext) begin failures++; $display("FAIL evt_ext got %b required %b", key_ext, e.ext); end
                    if (key_valid !== e.valid) begin failures++; $display("FAIL evt_valid got %b required %b", key_valid, e.valid); end
                    if (press_cnt !== e.cnt) begin failures++; $display("FAIL evt_cnt got %h required %h", press_cnt, e.cnt); end
                    if (key_ascii !== e.asc) begin failures++; $display("FAIL evt_ascii got %h required %h", key_ascii, e.asc); end
                end
            end
            prev = make_evt || break_evt;
        end
    end

    task automatic drain();
        int n = 0;
        int lim = 3 * fifo.size() + 50;
        while (fifo.size() != 0 && n < lim) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        checks++;
        if (n >= lim) begin failures++; $display("FAIL drain_timeout fifo=%0d required 0", fifo.size()); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL missing_events pending=%0d required 0", exp_q.size()); end
    endtask

    task automatic test_reset();
        #2 clr = 1;
        model_reset();
        repeat (2) @(negedge clk);
        checks += 8;
        if (nextdata_n !== 1'b1) begin failures++; $display("FAIL rst_nextdata_n got %b required 1", nextdata_n); end
        if (key_code !== 8'h00) begin failures++; $display("FAIL rst_key_code got %h required 00", key_code); end
        if (key_ext !== 1'b0) begin failures++; $display("FAIL rst_key_ext got %b required 0", key_ext); end
        if (key_valid !== 1'b0) begin failures++; $display("FAIL rst_key_valid got %b required 0", key_valid); end
        if (press_cnt !== 8'h00) begin failures++; $display("FAIL rst_press_cnt got %h required 00", press_cnt); end
        if (make_evt !== 1'b0 || break_evt !== 1'b0) begin failures++; $display("FAIL rst_evt got %b%b required 00", make_evt, break_evt); end
        if (err !== 1'b0) begin failures++; $display("FAIL rst_err got %b required 0", err); end
        if (key_ascii !== 8'h00) begin failures++; $display("FAIL rst_ascii got %h required 00", key_ascii); end
        clr = 0;
        @(negedge clk);
    endtask

    task automatic test_make_break();
        feed(8'h1C);
        drain();
        checks += 3;
        if (key_code !== 8'h1C) begin failures++; $display("FAIL mb_code got %h required 1c", key_code); end
        if (key_ascii !== 8'h61) begin failures++; $display("FAIL mb_ascii got %h required 61", key_ascii); end
        if (press_cnt !== 8'h01) begin failures++; $display("FAIL mb_cnt got %h required 01", press_cnt); end
        feed(8'hF0); feed(8'h1C);
        drain();
        checks += 2;
        if (key_valid !== 1'b0) begin failures++; $display("FAIL mb_release_valid got %b required 0", key_valid); end
        if (key_ascii !== 8'h00) begin failures++; $display("FAIL mb_release_ascii got %h required 00", key_ascii); end
    endtask

    task automatic test_typematic();
        int m0 = make_seen;
        feed(8'h1C); feed(8'h1C); feed(8'h1C); feed(8'hF0); feed(8'h1C);
        drain();
        checks += 3;
        if (make_seen - m0 != 1) begin failures++; $display("FAIL typ_makes got %0d required 1", make_seen - m0); end
        if (press_cnt !== m_cnt) begin failures++; $display("FAIL typ_cnt got %h required %h", press_cnt, m_cnt); end
        if (key_valid !== 1'b0) begin failures++; $display("FAIL typ_valid got %b required 0", key_valid); end
    endtask

    task automatic test_junk();
        feed(8'hE0); feed(8'hAA); feed(8'h1C);
        drain();
        checks += 2;
        if (key_ext !== 1'b0) begin failures++; $display("FAIL junk_ext got %b required 0", key_ext); end
        if (key_ascii !== 8'h61) begin failures++; $display("FAIL junk_ascii got %h required 61", key_ascii); end
        feed(8'hF0); feed(8'hF0); feed(8'h1C);
        drain();
        checks++;
        if (key_valid !== 1'b0) begin failures++; $display("FAIL junk_dbl_f0 valid got %b required 0", key_valid); end
    endtask

    task automatic test_ext();
        feed(8'hE0); feed(8'h75);
        drain();
        checks += 3;
        if (key_ext !== 1'b1) begin failures++; $display("FAIL ext_flag got %b required 1", key_ext); end
        if (key_code !== 8'h75) begin failures++; $display("FAIL ext_code got %h required 75", key_code); end
        if (key_ascii !== 8'h00) begin failures++; $display("FAIL ext_ascii got %h required 00", key_ascii); end
        feed(8'hF0); feed(8'h75);
        drain();
        checks++;
        if (key_valid !== 1'b1 || key_ext !== 1'b1) begin failures++; $display("FAIL ext_plain_break valid=%b ext=%b required 1 1", key_valid, key_ext); end
        feed(8'hE0); feed(8'hF0); feed(8'h75);
        drain();
        checks++;
        if (key_valid !== 1'b0) begin failures++; $display("FAIL ext_release valid got %b required 0", key_valid); end
    endtask

    task automatic test_wrap();
        bit t = 0;
        int m0;
        while (m_cnt != 8'hFF) begin feed(t ? 8'h32 : 8'h21); t = !t; end
        drain();
        checks++;
        if (press_cnt !== 8'hFF) begin failures++; $display("FAIL wrap_pre got %h required ff", press_cnt); end
        m0 = make_seen;
        feed(t ? 8'h32 : 8'h21);
        drain();
        checks += 2;
        if (press_cnt !== 8'h00) begin failures++; $display("FAIL wrap_cnt got %h required 00", press_cnt); end
        if (make_seen - m0 != 1) begin failures++; $display("FAIL wrap_make got %0d required 1", make_seen - m0); end
    endtask

    task automatic test_back_to_back();
        pops.delete();
        feed(8'h29); feed(8'h5A); feed(8'hF0); feed(8'h5A);
        drain();
        checks++;
        if (pops.size() != 4) begin failures++; $display("FAIL b2b_pops got %0d required 4", pops.size()); end
        else for (int i = 1; i < 4; i++) begin
            checks++;
            if (pops[i] - pops[i-1] != 3) begin failures++; $display("FAIL b2b_gap%0d got %0d required 3", i, pops[i] - pops[i-1]); end
        end
    endtask

    task automatic test_overflow_clr();
        int n = 0;
        overflow = 1;
        @(negedge clk);
        overflow = 0;
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL ovf_set got %b required 1", err); end
        repeat (5) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %b required 1", err); end
        feed(8'h1B);
        while (nextdata_n !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n >= 20) begin failures++; $display("FAIL clr_pop_timeout nextdata_n never low, required a pop"); end
        clr = 1;
        model_reset();
        #1;
        checks += 6;
        if (nextdata_n !== 1'b1) begin failures++; $display("FAIL clr_nextdata_n got %b required 1", nextdata_n); end
        if (key_valid !== 1'b0) begin failures++; $display("FAIL clr_valid got %b required 0", key_valid); end
        if (key_code !== 8'h00) begin failures++; $display("FAIL clr_code got %h required 00", key_code); end
        if (press_cnt !== 8'h00) begin failures++; $display("FAIL clr_cnt got %h required 00", press_cnt); end
        if (err !== 1'b0) begin failures++; $display("FAIL clr_err got %b required 0", err); end
        if (key_ascii !== 8'h00 || key_ext !== 1'b0) begin failures++; $display("FAIL clr_ascii_ext got %h %b required 00 0", key_ascii, key_ext); end
        repeat (2) @(negedge clk);
        clr = 0;
        @(negedge clk);
        feed(8'h1C);
        drain();
        checks++;
        if (press_cnt !== 8'h01 || key_code !== 8'h1C) begin failures++; $display("FAIL clr_resume cnt=%h code=%h required 01 1c", press_cnt, key_code); end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_make_break();
        test_typematic();
        test_junk();
        test_ext();
        test_wrap();
        test_back_to_back();
        test_overflow_clr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
